// File: rtl/tuple_replay_reader.sv
// Replay reader: reissues QDR reads over the stored tuple region for a number of passes and
// streams the returned records out as 5-tuple + pkt_len behind a credit-controlled buffer.
module tuple_replay_reader #(
  parameter int unsigned MEM_ADDR_WIDTH     = 19,
  parameter int unsigned MEM_DATA_WIDTH     = 144,
  parameter int unsigned PKT_TUPLE_WIDTH    = 104,
  parameter int unsigned PKT_LEN_WIDTH      = 16,
  parameter int unsigned REPLAY_COUNT_WIDTH = 32,
  parameter int unsigned BUF_DEPTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cal_done,
  input  logic                          sw_rst,
  input  logic                          start_replay,
  input  logic                          stop_replay,
  input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
  input  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_high,
  output logic                          app_rd_cmd,
  output logic [MEM_ADDR_WIDTH-1:0]     app_rd_addr,
  input  logic [MEM_DATA_WIDTH-1:0]     app_rd_data,
  input  logic                          app_rd_valid,
  output logic [PKT_TUPLE_WIDTH-1:0]    fivetuple_data_out,
  output logic [PKT_LEN_WIDTH-1:0]      pkt_len_out,
  output logic                          tuple_out_vld,
  input  logic                          tuple_out_ready,
  output logic                          replay_busy,
  output logic                          replay_done
);

  localparam int unsigned PtrW   = $clog2(BUF_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SumW   = CntW + 1;
  localparam int unsigned StoreW = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StDone, StFlush} state_e;

  state_e                        state_q, state_d;
  logic                          start_prev_q;
  logic [MEM_ADDR_WIDTH-1:0]     addr_q, addr_d, addr_lim_q, addr_lim_d;
  logic [REPLAY_COUNT_WIDTH-1:0] pass_q, pass_d, pass_lim_q, pass_lim_d;
  logic [CntW-1:0]               outstanding_q, outstanding_d, count_q, count_d;
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                          cmd_q, cmd_d, done_q, done_d;
  logic [MEM_ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic [StoreW-1:0]             fifo_mem_q [BUF_DEPTH];
  logic [StoreW-1:0]             head_word;
  logic                          start_edge, credit_ok, issue, ret, push, pop;
  logic                          unused_hi_bits;

  assign start_edge = start_replay & ~start_prev_q;
  // Outstanding reads already own a buffer slot, so they count against the depth.
  assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, count_q}) < SumW'(BUF_DEPTH);
  assign ret        = app_rd_valid && (outstanding_q != '0);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_lim_d = addr_lim_q;
    pass_d     = pass_q;
    pass_lim_d = pass_lim_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_addr_d  = rd_addr_q;
    cmd_d      = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (sw_rst) begin
      state_d  = StFlush;
      addr_d   = '0;
      pass_d   = '0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_edge && cal_done) begin
            if (mem_addr_high != '0) begin
              addr_lim_d = mem_addr_high;
              pass_lim_d = replay_count;
              addr_d     = '0;
              pass_d     = '0;
              state_d    = StRead;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StRead: begin
          if (stop_replay) begin
            state_d = StDrain;
          end else if (credit_ok) begin
            issue     = 1'b1;
            cmd_d     = 1'b1;
            rd_addr_d = addr_q;
            if (addr_q == addr_lim_q - MEM_ADDR_WIDTH'(1)) begin
              addr_d = '0;
              pass_d = pass_q + REPLAY_COUNT_WIDTH'(1);
              if ((pass_lim_q != '0) && (pass_q + REPLAY_COUNT_WIDTH'(1) == pass_lim_q)) begin
                state_d = StDrain;
              end
            end else begin
              addr_d = addr_q + MEM_ADDR_WIDTH'(1);
            end
          end
        end
        StDrain: if ((outstanding_q == '0) && (count_q == '0)) state_d = StDone;
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        StFlush: if (outstanding_q == '0) state_d = StIdle;
        default: state_d = StIdle;
      endcase
      // Returns arriving while flushing belong to the aborted replay and are dropped.
      push     = ret && (state_q != StFlush);
      pop      = tuple_out_vld && tuple_out_ready;
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push) - CntW'(pop);
    end
    outstanding_d = outstanding_q + CntW'(issue) - CntW'(ret);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      start_prev_q  <= 1'b0;
      addr_q        <= '0;
      addr_lim_q    <= '0;
      pass_q        <= '0;
      pass_lim_q    <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_q         <= 1'b0;
      rd_addr_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_replay;
      addr_q        <= addr_d;
      addr_lim_q    <= addr_lim_d;
      pass_q        <= pass_d;
      pass_lim_q    <= pass_lim_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmd_q         <= cmd_d;
      rd_addr_q     <= rd_addr_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= app_rd_data[StoreW-1:0];
  end

  assign unused_hi_bits     = ^app_rd_data[MEM_DATA_WIDTH-1:StoreW];
  assign head_word          = fifo_mem_q[rd_ptr_q];
  assign fivetuple_data_out = head_word[PKT_TUPLE_WIDTH-1:0];
  assign pkt_len_out        = head_word[StoreW-1:PKT_TUPLE_WIDTH];
  assign tuple_out_vld      = (count_q != '0);
  assign app_rd_cmd         = cmd_q;
  assign app_rd_addr        = rd_addr_q;
  assign replay_busy        = (state_q != StIdle);
  assign replay_done        = done_q;

endmodule

// File: tb/tb_tuple_replay_reader.sv
// Bench for tuple_replay_reader: random memory image and latency, reference sequence derived
// from pass/address arithmetic, randomized downstream backpressure.
module tb_tuple_replay_reader;
  localparam int AW = 19, DW = 144, TW = 104, LW = 16, RW = 32, DEPTH = 16;

  logic          clk = 1'b0, rst, cal_done, sw_rst, start_replay, stop_replay;
  logic [RW-1:0] replay_count;
  logic [AW-1:0] mem_addr_high, app_rd_addr;
  logic          app_rd_cmd, app_rd_valid, tuple_out_vld, tuple_out_ready;
  logic [DW-1:0] app_rd_data;
  logic [TW-1:0] fivetuple_data_out;
  logic [LW-1:0] pkt_len_out;
  logic          replay_busy, replay_done;

  tuple_replay_reader #(
    .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .PKT_TUPLE_WIDTH(TW), .PKT_LEN_WIDTH(LW),
    .REPLAY_COUNT_WIDTH(RW), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cal_done(cal_done), .sw_rst(sw_rst), .start_replay(start_replay),
    .stop_replay(stop_replay), .replay_count(replay_count), .mem_addr_high(mem_addr_high),
    .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr), .app_rd_data(app_rd_data),
    .app_rd_valid(app_rd_valid), .fivetuple_data_out(fivetuple_data_out),
    .pkt_len_out(pkt_len_out), .tuple_out_vld(tuple_out_vld), .tuple_out_ready(tuple_out_ready),
    .replay_busy(replay_busy), .replay_done(replay_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]  mem_img [64];
  int             lat;
  bit             rand_ready;
  int unsigned    pend_addr[$];
  longint         pend_due[$];
  int unsigned    cmd_log[$];
  logic [119:0]   out_q[$];
  longint         cyc = 0;
  int             done_cnt;
  bit             busy_at_done, busy_seen;
  int             n_cmp = 0, n_err = 0;

  // QDR model: fixed latency per command, returns in issue order.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      app_rd_valid = 1'b0;
    end else begin
      if (app_rd_cmd) begin
        cmd_log.push_back(int'(app_rd_addr));
        pend_addr.push_back(int'(app_rd_addr));
        pend_due.push_back(cyc + lat);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        app_rd_valid = 1'b1;
        app_rd_data  = mem_img[pend_addr[0] % 64];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        app_rd_valid = 1'b0;
        app_rd_data  = '0;
      end
    end
    if (rand_ready) tuple_out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tuple_out_vld && tuple_out_ready) out_q.push_back({pkt_len_out, fivetuple_data_out});
      if (replay_done) begin
        done_cnt++;
        busy_at_done = replay_busy;
      end
      if (replay_busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic new_test();
    logic [159:0] w;
    cmd_log.delete();
    out_q.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      mem_img[i] = w[DW-1:0];
    end
  endtask

  task automatic pulse_start(input int mah, input int rc);
    mem_addr_high = AW'(mah);
    replay_count  = RW'(rc);
    start_replay  = 1'b1;
    tick(2);
    start_replay  = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      tick(1);
      i++;
    end
    check({tag, " replay_done seen"}, 128'(done_cnt != 0), 128'(1));
  endtask

  // Expected stream: the i-th issued read is address i mod words; data is that stored word.
  task automatic verify_run(input string tag, input int n_exp, input int n_words);
    check({tag, " out count"}, out_q.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < cmd_log.size()) check({tag, " addr"}, cmd_log[i], i % n_words);
      if (i < out_q.size()) check({tag, " tuple"}, out_q[i], mem_img[i % n_words][119:0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [119:0] head;
    int n_stop, i;
    rst = 1'b1; sw_rst = 1'b0; cal_done = 1'b1; start_replay = 1'b0; stop_replay = 1'b0;
    replay_count = '0; mem_addr_high = '0; tuple_out_ready = 1'b0; rand_ready = 1'b0;
    app_rd_valid = 1'b0; app_rd_data = '0; lat = 8;
    tick(3);
    check("reset cmd", app_rd_cmd, 0);
    check("reset addr", app_rd_addr, 0);
    check("reset vld", tuple_out_vld, 0);
    check("reset busy", replay_busy, 0);
    check("reset done", replay_done, 0);
    rst = 1'b0;
    tick(2);

    // Two passes over five words, no backpressure.
    new_test();
    lat = 8;
    tuple_out_ready = 1'b1;
    pulse_start(5, 2);
    wait_done("t1", 400);
    tick(3);
    check("t1 cmd count", cmd_log.size(), 10);
    verify_run("t1", 10, 5);
    check("t1 done count", done_cnt, 1);
    check("t1 busy during done", busy_at_done, 0);
    check("t1 busy after", replay_busy, 0);

    // Stalled downstream: credits cap issue at buffer depth.
    new_test();
    lat = $urandom_range(1, 6);
    tuple_out_ready = 1'b0;
    pulse_start(40, 1);
    tick(100);
    check("t2 credit-limited cmds", cmd_log.size(), DEPTH);
    check("t2 vld held", tuple_out_vld, 1);
    head = {pkt_len_out, fivetuple_data_out};
    check("t2 head word", head, mem_img[0][119:0]);
    tick(10);
    check("t2 head stable", {pkt_len_out, fivetuple_data_out}, head);
    rand_ready = 1'b1;
    wait_done("t2", 2000);
    tick(3);
    check("t2 cmd count", cmd_log.size(), 40);
    verify_run("t2", 40, 40);
    rand_ready = 1'b0;
    tuple_out_ready = 1'b1;

    // Endless loop stopped by stop_replay.
    new_test();
    lat = $urandom_range(1, 10);
    rand_ready = 1'b1;
    pulse_start(3, 0);
    i = 0;
    while (cmd_log.size() < 20 && i < 500) begin
      tick(1);
      i++;
    end
    check("t3 reached 20 cmds", 128'(cmd_log.size() >= 20), 128'(1));
    n_stop = cmd_log.size();
    stop_replay = 1'b1;
    tick(4);
    check("t3 stop latency", 128'(cmd_log.size() - n_stop <= 1), 128'(1));
    wait_done("t3", 500);
    stop_replay = 1'b0;
    tick(3);
    verify_run("t3", cmd_log.size(), 3);
    check("t3 done count", done_cnt, 1);
    rand_ready = 1'b0;

    // Soft reset with reads in flight.
    new_test();
    lat = 4;
    tuple_out_ready = 1'b0;
    pulse_start(30, 1);
    i = 0;
    while (cmd_log.size() < 10 && i < 200) begin
      tick(1);
      i++;
    end
    check("t4 vld before sw_rst", tuple_out_vld, 1);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    check("t4 vld cleared", tuple_out_vld, 0);
    tuple_out_ready = 1'b1;
    i = 0;
    while (replay_busy && i < 200) begin
      tick(1);
      i++;
    end
    check("t4 idle reached", replay_busy, 0);
    check("t4 returns drained first", pend_addr.size(), 0);
    tick(5);
    check("t4 flushed data not output", out_q.size(), 0);
    check("t4 no done pulse", done_cnt, 0);
    new_test();
    pulse_start(4, 1);
    wait_done("t4 restart", 300);
    tick(3);
    check("t4 restart cmd count", cmd_log.size(), 4);
    verify_run("t4 restart", 4, 4);

    // Start ignored without calibration; empty region completes immediately.
    new_test();
    cal_done = 1'b0;
    pulse_start(5, 1);
    tick(20);
    check("t5 nocal cmds", cmd_log.size(), 0);
    check("t5 nocal busy", busy_seen, 0);
    check("t5 nocal done", done_cnt, 0);
    cal_done = 1'b1;
    new_test();
    pulse_start(0, 1);
    tick(10);
    check("t5 empty cmds", cmd_log.size(), 0);
    check("t5 empty done count", done_cnt, 1);
    check("t5 empty busy", busy_seen, 0);

    // Asynchronous reset mid-replay, then a clean replay.
    new_test();
    lat = 3;
    rand_ready = 1'b1;
    pulse_start(20, 3);
    i = 0;
    while (cmd_log.size() < 8 && i < 200) begin
      tick(1);
      i++;
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6 async cmd", app_rd_cmd, 0);
    check("t6 async addr", app_rd_addr, 0);
    check("t6 async vld", tuple_out_vld, 0);
    check("t6 async busy", replay_busy, 0);
    check("t6 async done", replay_done, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    new_test();
    pulse_start(6, 1);
    wait_done("t6", 400);
    tick(3);
    check("t6 cmd count", cmd_log.size(), 6);
    verify_run("t6", 6, 6);
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tuple_replay_reader.md
Name: tuple_replay_reader

Overview:
- Replay-side reader of the dflow tuple store: re-reads tuple records from QDR (written earlier by the store path) and emits them as a 5-tuple + pkt_len valid/ready stream to the downstream packet generator.
- Issues QDR read commands at addresses 0..mem_addr_high-1 for a programmable number of passes.
- Buffers returned data in an internal credit-controlled FIFO.
- Unpacks one 144-bit memory word into one tuple record.

Parameters:
- MEM_ADDR_WIDTH, 19, QDR address width.
- MEM_DATA_WIDTH, 144, QDR burst word width.
- PKT_TUPLE_WIDTH, 104, 5-tuple width.
- PKT_LEN_WIDTH, 16, packet length width.
- REPLAY_COUNT_WIDTH, 32, pass counter width.
- BUF_DEPTH, 16, internal buffer depth in words; power of two, at least 4.

Ports:
- clk  in  1  QDR user clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cal_done  in  1  QDR calibration complete.
- sw_rst  in  1  synchronous soft reset; flushes the block.
- start_replay  in  1  level from register; rising edge starts a replay.
- stop_replay  in  1  level; stops issue, then drains.
- replay_count  in  REPLAY_COUNT_WIDTH  number of passes; 0 = loop until stop_replay.
- mem_addr_high  in  MEM_ADDR_WIDTH  number of valid stored words; sampled at start.
- app_rd_cmd  out  1  read command strobe.
- app_rd_addr  out  MEM_ADDR_WIDTH  read address.
- app_rd_data  in  MEM_DATA_WIDTH  read data.
- app_rd_valid  in  1  read data valid.
- fivetuple_data_out  out  PKT_TUPLE_WIDTH  tuple = buffered word [103:0].
- pkt_len_out  out  PKT_LEN_WIDTH  length = buffered word [119:104].
- tuple_out_vld  out  1  output valid.
- tuple_out_ready  in  1  downstream ready.
- replay_busy  out  1  high in any state other than IDLE.
- replay_done  out  1  one-cycle pulse when a replay completes.

Behaviour:
- Reset (rst = 1): state IDLE; app_rd_cmd, app_rd_addr, tuple_out_vld, replay_busy, replay_done all 0; buffer empty; all counters 0.
- Start edge detect: one register holds the previous start_replay.
- IDLE:
  - Start condition: rising edge of start_replay with cal_done = 1 and mem_addr_high != 0.
  - On start: latch mem_addr_high into addr_lim and replay_count into pass_lim; addr = 0; pass = 0; go to READ.
  - Rising edge with mem_addr_high == 0: no reads; pulse replay_done next cycle; stay IDLE.
  - Rising edge with cal_done = 0: ignored.
- Credits: outstanding counter (issued commands not yet returned) + buffer occupancy must be at most BUF_DEPTH.
  - A command is issued only when outstanding + occupancy < BUF_DEPTH.
- READ:
  - Each issuing cycle: app_rd_cmd = 1, app_rd_addr = addr (registered outputs); at most one command per cycle.
  - After issuing addr == addr_lim-1: addr wraps to 0 and pass increments.
  - Exit to DRAIN when pass + 1 == pass_lim at the wrap and pass_lim != 0.
  - stop_replay = 1: no further commands; go to DRAIN.
- DRAIN: no commands; wait for outstanding == 0 and buffer empty, then go to DONE.
- DONE: replay_done = 1 for one cycle; go to IDLE.
- Return path:
  - app_rd_valid writes app_rd_data into the buffer and decrements outstanding.
  - Simultaneous issue and return leave outstanding unchanged.
  - Overflow is impossible by the credit rule.
  - Bits [143:120] are ignored.
- Output:
  - Show-ahead buffer: tuple_out_vld = buffer not empty.
  - Data presented is the head word; pop on tuple_out_vld && tuple_out_ready.
  - Data and valid hold stable while vld && !ready.
  - Latency: app_rd_valid in cycle N gives tuple_out_vld in cycle N+1 when the buffer was empty.
  - Order equals issue order.
- Simultaneous push and pop: occupancy unchanged. Push to a full buffer and pop from an empty buffer never occur.
- sw_rst (any state, priority over everything except rst):
  - Clear buffer, addr and pass; tuple_out_vld = 0; app_rd_cmd = 0; go to FLUSH.
  - FLUSH discards app_rd_valid returns, decrementing outstanding; go to IDLE when outstanding == 0 and sw_rst == 0.
  - replay_busy = 1 in FLUSH; no replay_done pulse.
- Start edges outside IDLE are ignored.
- Counter widths: addr MEM_ADDR_WIDTH; outstanding and occupancy log2(BUF_DEPTH)+1 bits; pass REPLAY_COUNT_WIDTH, wrapping silently when pass_lim = 0.

Test Plan:
- mem_addr_high = 5, replay_count = 2, ready tied 1, read latency 8 -> 10 commands at addresses 0,1,2,3,4,0,1,2,3,4; 10 tuples out in order with pkt_len = word[119:104]; one replay_done pulse; replay_busy falls with it.
- mem_addr_high = 40, replay_count = 1, ready = 0 -> exactly 16 commands issued, then none; tuple_out_vld = 1 holding word 0 unchanged; releasing ready yields all 40 tuples, none lost.
- replay_count = 0, mem_addr_high = 3, stop_replay asserted after 20 commands -> addresses cycle 0,1,2 continuously; issue stops within 1 cycle of stop; all outstanding data delivered; replay_done pulses.
- sw_rst mid-READ with 6 reads outstanding -> tuple_out_vld = 0 next cycle; the 6 returns are dropped; IDLE reached after the last return; no replay_done pulse; a new start replays from address 0.
- Start edge with cal_done = 0 -> no commands, busy stays 0. Start edge with mem_addr_high = 0 -> no commands, single replay_done pulse.
- rst asserted mid-replay, asynchronously -> all outputs 0 immediately; the next start runs a clean replay.
